// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator running on the system clock.
// Produces a pixel clock-enable, raster counters, registered sync/data-enable
// decode (one clk behind the counters) and line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_ce,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div;
  logic [31:0]      h_ext;
  logic [31:0]      v_ext;

  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  // Divider: one registered pix_ce pulse each time the divider wraps.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else if (en) begin
      if (div == DIV_LAST) begin
        div    <= '0;
        pix_ce <= 1'b1;
      end else begin
        div    <= div + 1'b1;
        pix_ce <= 1'b0;
      end
    end else begin
      pix_ce <= 1'b0;
      // A pulse swallowed by en=0 is not consumed: park the divider at its
      // last count so the first enabled clk reissues it and no pixel is lost.
      if (pix_ce) div <= DIV_LAST;
    end
  end

  // Raster counters and start pulses, advancing on enabled pix_ce clks.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en && pix_ce) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (h_cnt == H_LAST) begin
        h_cnt      <= '0;
        line_start <= 1'b1;
        if (v_cnt == V_LAST) begin
          v_cnt       <= '0;
          frame_start <= 1'b1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Sync and data-enable decode, registered from the current counters.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      de <= 1'b0;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
    end else if (en) begin
      de <= (h_ext < H_VISIBLE) && (v_ext < V_VISIBLE);
      hs <= ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
      vs <= ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/LCD raster timing generator: successor to the fixed 640x480 timing block, with all porch/sync/visible widths, sync polarities and the pixel-clock divide ratio set by parameters.
- Runs on the system clock and produces a pixel clock-enable rather than a derived clock.
- Outputs raster counters, sync strobes, a data-enable and line/frame start pulses.
- Feeds the pixel fetch/scaler path and the VGA pins.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- CLK_DIV, 2, system clocks per pixel (>=1)
- CNT_W, 11, counter width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clk_50  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- en  in  1  run enable; 0 freezes timing
- pix_ce  out  1  pixel clock-enable, one clk wide
- h_cnt  out  CNT_W  horizontal pixel counter
- v_cnt  out  CNT_W  vertical line counter
- hs  out  1  horizontal sync, polarity HS_POL
- vs  out  1  vertical sync, polarity VS_POL
- de  out  1  active-video data enable
- line_start  out  1  one-clk pulse at start of each line
- frame_start  out  1  one-clk pulse at start of each frame

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Line order is visible, front porch, sync, back porch, both axes.
- Reset: rst_n sampled low on a clk_50 edge sets every output on that edge:
  - divider = 0, h_cnt = 0, v_cnt = 0, pix_ce = 0, de = 0, line_start = 0, frame_start = 0
  - hs = ~HS_POL, vs = ~VS_POL
  - Reset mid-frame behaves identically; no partial line completes.
- Divider:
  - Counts 0..CLK_DIV-1 on each clk with en=1.
  - pix_ce is registered, high for exactly one clk when the divider wraps.
  - CLK_DIV=1: pix_ce is high every enabled clk.
  - First pix_ce occurs CLK_DIV clks after reset release (en=1).
- Counters advance only on clks where pix_ce=1:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
- Decode: registered from the current h_cnt/v_cnt on every enabled clk, so it lags the counters by 1 clk.
  - de = 1 when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
  - hs = HS_POL when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, else ~HS_POL.
  - vs = VS_POL when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, else ~VS_POL. vs changes only at line boundaries.
- Start pulses:
  - line_start: high for one clk, the clk after any pix_ce edge that wrapped h_cnt to 0.
  - frame_start: high for one clk, the clk after the pix_ce edge that wrapped both counters. line_start is also high in that clk.
  - Neither pulse fires on reset release.
- en=0: divider, counters and decoded outputs hold their values; pix_ce, line_start and frame_start are forced 0. Resuming en=1 continues from the held divider value with no skipped pixel.
- rst_n has priority over en.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1 under any sequence.

Test Plan:
- Default params, CLK_DIV=2, en=1 after reset:
  - pix_ce every 2nd clk
  - h_cnt wraps 799->0
  - v_cnt wraps 524->0
  - frame_start period = 800*525*2 = 840000 clks
  - line_start period = 1600 clks
- Default params, sync/de windows:
  - hs low exactly for h_cnt 656..751 (96 pixels)
  - vs low for v_cnt 490..491
  - de high only for h<640 and v<480: 640*480 = 307200 pix_ce cycles per frame with de=1
- Small params H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1:
  - H_TOTAL 8, V_TOTAL 6
  - hs high at h_cnt 5..6
  - vs high at v_cnt 4
  - frame_start every 48 clks
- Reset mid-frame at h_cnt=300, v_cnt=200:
  - next edge all counters 0, hs/vs inactive, de=0
  - de=1 one clk after release
  - no line_start/frame_start pulse on release
- en toggled low for 5 clks at divider=1:
  - counters and hs/vs/de hold
  - pix_ce stays 0
  - after en=1, next pix_ce after 1 clk
  - frame length grows by exactly 5 clks
- CLK_DIV=3, en=1:
  - pix_ce duty 1 in 3
  - first pix_ce 3 clks after reset release
  - h_cnt steps once per 3 clks
